// File: rtl/alu_axil_pkg.sv
// Shared definitions for the ALU AXI4-Lite register front-end:
// register offsets, response codes, opcodes and FSM states.
package alu_axil_pkg;

  localparam logic [4:0] OPA_OFS    = 5'h00;
  localparam logic [4:0] OPB_OFS    = 5'h04;
  localparam logic [4:0] OPCODE_OFS = 5'h08;
  localparam logic [4:0] RESULT_OFS = 5'h0C;
  localparam logic [4:0] WRCNT_OFS  = 5'h10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    ADD = 3'd0,
    AND = 3'd1,
    XOR = 3'd2
  } opcode_e;

  typedef enum logic [2:0] {
    W_IDLE,
    W_HAVE_AW,
    W_HAVE_W,
    W_COMMIT,
    W_RESP
  } wr_state_e;

  typedef enum logic {
    R_IDLE,
    R_DATA
  } rd_state_e;

endpackage

// File: rtl/alu_axil_regs.sv
// AXI4-Lite register front-end driving the 8-bit ALU operands/opcode.
// Optional write counter at 0x10 enabled by ALU_AXIL_WR_COUNT_EN.
module alu_axil_regs
  import alu_axil_pkg::*;
#(
  parameter int          ADDR_WIDTH = 5,
  parameter int          DATA_WIDTH = 32,
  parameter logic [2:0]  OPCODE_RST = ADD
) (
  input  logic                  ACLK,
  input  logic                  ARESETN,
  input  logic [ADDR_WIDTH-1:0] AWADDR,
  input  logic [2:0]            AWPROT,
  input  logic                  AWVALID,
  output logic                  AWREADY,
  input  logic [DATA_WIDTH-1:0] WDATA,
  input  logic [3:0]            WSTRB,
  input  logic                  WVALID,
  output logic                  WREADY,
  output logic [1:0]            BRESP,
  output logic                  BVALID,
  input  logic                  BREADY,
  input  logic [ADDR_WIDTH-1:0] ARADDR,
  input  logic [2:0]            ARPROT,
  input  logic                  ARVALID,
  output logic                  ARREADY,
  output logic [DATA_WIDTH-1:0] RDATA,
  output logic [1:0]            RRESP,
  output logic                  RVALID,
  input  logic                  RREADY,
  output logic [7:0]            operandA,
  output logic [7:0]            operandB,
  output logic [2:0]            opp_code,
  input  logic [7:0]            alu_result
);

  wr_state_e wr_state_q, wr_state_d;
  rd_state_e rd_state_q, rd_state_d;

  logic       awready_q, awready_d;
  logic       wready_q, wready_d;
  logic       bvalid_q, bvalid_d;
  logic [1:0] bresp_q, bresp_d;
  logic [2:0] aw_idx_q, aw_idx_d;
  logic [7:0] wdata_q, wdata_d;
  logic       wstrb0_q, wstrb0_d;
  logic [7:0] opa_q, opa_d;
  logic [7:0] opb_q, opb_d;
  logic [2:0] opc_q, opc_d;

  logic        arready_q, arready_d;
  logic        rvalid_q, rvalid_d;
  logic [31:0] rdata_q, rdata_d;
  logic [1:0]  rresp_q, rresp_d;

  logic        aw_hs, w_hs, ar_hs;
  logic        reg_hit;
  logic        cnt_hit;
  logic [2:0]  rd_idx;
  logic [31:0] rd_val;
  logic [1:0]  rd_resp;
  logic        unused_bits;

`ifdef ALU_AXIL_WR_COUNT_EN
  logic [31:0] wrcnt_q, wrcnt_d;
`endif

  assign aw_hs = AWVALID & awready_q;
  assign w_hs  = WVALID & wready_q;
  assign ar_hs = ARVALID & arready_q;

  assign unused_bits = ^{AWPROT, ARPROT, WSTRB[3:1],
                         WDATA[DATA_WIDTH-1:8],
                         AWADDR[1:0], ARADDR[1:0]};

  always_comb begin
    wr_state_d = wr_state_q;
    aw_idx_d   = aw_idx_q;
    wdata_d    = wdata_q;
    wstrb0_d   = wstrb0_q;
    bvalid_d   = bvalid_q;
    bresp_d    = bresp_q;
    opa_d      = opa_q;
    opb_d      = opb_q;
    opc_d      = opc_q;
    reg_hit    = 1'b0;
    cnt_hit    = 1'b0;
`ifdef ALU_AXIL_WR_COUNT_EN
    wrcnt_d    = wrcnt_q;
`endif
    if (aw_hs) aw_idx_d = AWADDR[4:2];
    if (w_hs) begin
      wdata_d  = WDATA[7:0];
      wstrb0_d = WSTRB[0];
    end
    unique case (wr_state_q)
      W_IDLE: begin
        if (aw_hs && w_hs) wr_state_d = W_COMMIT;
        else if (aw_hs)    wr_state_d = W_HAVE_AW;
        else if (w_hs)     wr_state_d = W_HAVE_W;
      end
      W_HAVE_AW: if (w_hs)  wr_state_d = W_COMMIT;
      W_HAVE_W:  if (aw_hs) wr_state_d = W_COMMIT;
      W_COMMIT: begin
        unique case (1'b1)
          (aw_idx_q == OPA_OFS[4:2]): begin
            reg_hit = 1'b1;
            if (wstrb0_q) opa_d = wdata_q;
          end
          (aw_idx_q == OPB_OFS[4:2]): begin
            reg_hit = 1'b1;
            if (wstrb0_q) opb_d = wdata_q;
          end
          (aw_idx_q == OPCODE_OFS[4:2]): begin
            reg_hit = 1'b1;
            if (wstrb0_q) opc_d = wdata_q[2:0];
          end
`ifdef ALU_AXIL_WR_COUNT_EN
          (aw_idx_q == WRCNT_OFS[4:2]): begin
            cnt_hit = 1'b1;
            wrcnt_d = '0;
          end
`endif
          default: ;
        endcase
`ifdef ALU_AXIL_WR_COUNT_EN
        if (reg_hit) wrcnt_d = wrcnt_q + 32'd1;
`endif
        bresp_d    = (reg_hit || cnt_hit) ? RESP_OKAY
                                          : RESP_SLVERR;
        bvalid_d   = 1'b1;
        wr_state_d = W_RESP;
      end
      W_RESP: begin
        if (BREADY) begin
          bvalid_d   = 1'b0;
          wr_state_d = W_IDLE;
        end
      end
      default: wr_state_d = W_IDLE;
    endcase
    awready_d = (wr_state_d == W_IDLE) ||
                (wr_state_d == W_HAVE_W);
    wready_d  = (wr_state_d == W_IDLE) ||
                (wr_state_d == W_HAVE_AW);
  end

  // Read mux sees pre-write values when a write commits the same edge.
  always_comb begin
    rd_idx  = ARADDR[4:2];
    rd_val  = '0;
    rd_resp = RESP_SLVERR;
    unique case (1'b1)
      (rd_idx == OPA_OFS[4:2]): begin
        rd_val  = {24'b0, opa_q};
        rd_resp = RESP_OKAY;
      end
      (rd_idx == OPB_OFS[4:2]): begin
        rd_val  = {24'b0, opb_q};
        rd_resp = RESP_OKAY;
      end
      (rd_idx == OPCODE_OFS[4:2]): begin
        rd_val  = {29'b0, opc_q};
        rd_resp = RESP_OKAY;
      end
      (rd_idx == RESULT_OFS[4:2]): begin
        rd_val  = {24'b0, alu_result};
        rd_resp = RESP_OKAY;
      end
`ifdef ALU_AXIL_WR_COUNT_EN
      (rd_idx == WRCNT_OFS[4:2]): begin
        rd_val  = wrcnt_q;
        rd_resp = RESP_OKAY;
      end
`else
      (rd_idx == WRCNT_OFS[4:2]): ;
`endif
      default: ;
    endcase
  end

  always_comb begin
    rd_state_d = rd_state_q;
    rvalid_d   = rvalid_q;
    rdata_d    = rdata_q;
    rresp_d    = rresp_q;
    unique case (rd_state_q)
      R_IDLE: begin
        if (ar_hs) begin
          rdata_d    = rd_val;
          rresp_d    = rd_resp;
          rvalid_d   = 1'b1;
          rd_state_d = R_DATA;
        end
      end
      R_DATA: begin
        if (RREADY) begin
          rvalid_d   = 1'b0;
          rd_state_d = R_IDLE;
        end
      end
      default: rd_state_d = R_IDLE;
    endcase
    arready_d = (rd_state_d == R_IDLE);
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      wr_state_q <= W_IDLE;
      rd_state_q <= R_IDLE;
      awready_q  <= 1'b0;
      wready_q   <= 1'b0;
      bvalid_q   <= 1'b0;
      bresp_q    <= RESP_OKAY;
      aw_idx_q   <= '0;
      wdata_q    <= '0;
      wstrb0_q   <= 1'b0;
      opa_q      <= '0;
      opb_q      <= '0;
      opc_q      <= OPCODE_RST;
      arready_q  <= 1'b0;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
      rresp_q    <= RESP_OKAY;
`ifdef ALU_AXIL_WR_COUNT_EN
      wrcnt_q    <= '0;
`endif
    end else begin
      wr_state_q <= wr_state_d;
      rd_state_q <= rd_state_d;
      awready_q  <= awready_d;
      wready_q   <= wready_d;
      bvalid_q   <= bvalid_d;
      bresp_q    <= bresp_d;
      aw_idx_q   <= aw_idx_d;
      wdata_q    <= wdata_d;
      wstrb0_q   <= wstrb0_d;
      opa_q      <= opa_d;
      opb_q      <= opb_d;
      opc_q      <= opc_d;
      arready_q  <= arready_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
      rresp_q    <= rresp_d;
`ifdef ALU_AXIL_WR_COUNT_EN
      wrcnt_q    <= wrcnt_d;
`endif
    end
  end

  assign AWREADY  = awready_q;
  assign WREADY   = wready_q;
  assign BVALID   = bvalid_q;
  assign BRESP    = bresp_q;
  assign ARREADY  = arready_q;
  assign RVALID   = rvalid_q;
  assign RDATA    = rdata_q;
  assign RRESP    = rresp_q;
  assign operandA = opa_q;
  assign operandB = opb_q;
  assign opp_code = opc_q;

endmodule

// File: tb/tb_alu_axil_regs.sv
// Self-checking bench for alu_axil_regs against a register-map model.
// Covers the ALU_AXIL_WR_COUNT_EN build when that macro is defined.
module tb_alu_axil_regs;

  logic        ACLK = 1'b0;
  logic        ARESETN;
  logic [4:0]  AWADDR;
  logic [2:0]  AWPROT;
  logic        AWVALID;
  logic        AWREADY;
  logic [31:0] WDATA;
  logic [3:0]  WSTRB;
  logic        WVALID;
  logic        WREADY;
  logic [1:0]  BRESP;
  logic        BVALID;
  logic        BREADY;
  logic [4:0]  ARADDR;
  logic [2:0]  ARPROT;
  logic        ARVALID;
  logic        ARREADY;
  logic [31:0] RDATA;
  logic [1:0]  RRESP;
  logic        RVALID;
  logic        RREADY;
  logic [7:0]  operandA;
  logic [7:0]  operandB;
  logic [2:0]  opp_code;
  logic [7:0]  alu_result;

  int n_err = 0;
  int n_checks = 0;
  bit mon_en = 0;
  bit wr_busy = 0;

  logic [7:0]  m_opa;
  logic [7:0]  m_opb;
  logic [2:0]  m_opc;
  logic [31:0] m_cnt;
  logic [1:0]  exp_b[$];
  logic [33:0] exp_r[$];

  always #5 ACLK = ~ACLK;

  alu_axil_regs dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .AWADDR(AWADDR), .AWPROT(AWPROT),
    .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB),
    .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARPROT(ARPROT),
    .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP),
    .RVALID(RVALID), .RREADY(RREADY),
    .operandA(operandA), .operandB(operandB),
    .opp_code(opp_code), .alu_result(alu_result)
  );

  function automatic logic [7:0] alu_f(
    input logic [7:0] a, input logic [7:0] b,
    input logic [2:0] op);
    case (op)
      3'd0:    return a + b;
      3'd1:    return a & b;
      3'd2:    return a ^ b;
      default: return 8'h00;
    endcase
  endfunction

  assign alu_result = alu_f(operandA, operandB, opp_code);

  task automatic chk(input string nm,
                     input logic [33:0] act,
                     input logic [33:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [33:0] model_read(input logic [4:0] a);
    case (a[4:2])
      3'd0: return {2'b00, 24'h0, m_opa};
      3'd1: return {2'b00, 24'h0, m_opb};
      3'd2: return {2'b00, 29'h0, m_opc};
      3'd3: return {2'b00, 24'h0, alu_f(m_opa, m_opb, m_opc)};
`ifdef ALU_AXIL_WR_COUNT_EN
      3'd4: return {2'b00, m_cnt};
`endif
      default: return {2'b10, 32'h0};
    endcase
  endfunction

  function automatic logic [1:0] model_bresp(input logic [4:0] a);
    if (a[4:2] <= 3'd2) return 2'b00;
`ifdef ALU_AXIL_WR_COUNT_EN
    if (a[4:2] == 3'd4) return 2'b00;
`endif
    return 2'b10;
  endfunction

  task automatic model_write(input logic [4:0] a,
                             input logic [31:0] d,
                             input logic [3:0] s);
    case (a[4:2])
      3'd0: if (s[0]) m_opa = d[7:0];
      3'd1: if (s[0]) m_opb = d[7:0];
      3'd2: if (s[0]) m_opc = d[2:0];
      default: ;
    endcase
    if (a[4:2] <= 3'd2) m_cnt = m_cnt + 32'd1;
    if (a[4:2] == 3'd4) m_cnt = 32'd0;
  endtask

  task automatic do_write(input logic [4:0] a,
                          input logic [31:0] d,
                          input logic [3:0] s,
                          input int aw_dly, input int w_dly,
                          input int b_dly,
                          output logic [1:0] br);
    int hs_k = 0;
    int first = -1;
    bit aw_done = 0, w_done = 0, done = 0;
    bit aw_fire = 0, w_fire = 0, b_fire = 0;
    br = 2'b11;
    exp_b.push_back(model_bresp(a));
    wr_busy = 1;
    for (int k = 0; k < 100 && !done; k++) begin
      @(posedge ACLK); #1;
      if (b_fire) begin
        BREADY = 0;
        done = 1;
        chk("ready_after_b", {AWREADY, WREADY}, 2'b11);
      end else begin
        if (aw_fire) begin AWVALID = 0; aw_done = 1; end
        if (w_fire)  begin WVALID = 0;  w_done = 1;  end
        if (!aw_done && k >= aw_dly) begin
          AWVALID = 1; AWADDR = a;
        end
        if (!w_done && k >= w_dly) begin
          WVALID = 1; WDATA = d; WSTRB = s;
        end
        aw_fire = AWVALID && AWREADY;
        w_fire  = WVALID && WREADY;
        if (aw_fire || w_fire) hs_k = k;
        if (BVALID) begin
          if (first < 0) begin
            first = k;
            chk("b_latency", k - hs_k - 1, 1);
          end
          br = BRESP;
          if (k - first >= b_dly) BREADY = 1;
          else chk("ready_low_in_b", {AWREADY, WREADY}, 2'b00);
        end
        b_fire = BVALID && BREADY;
      end
    end
    if (!done) begin
      n_checks++; n_err++;
      $display("FAIL wr_timeout: got no B for addr %h", a);
      AWVALID = 0; WVALID = 0; BREADY = 0;
    end
    model_write(a, d, s);
    wr_busy = 0;
  endtask

  task automatic do_read(input logic [4:0] a,
                         input int ar_dly, input int r_dly,
                         output logic [31:0] rd,
                         output logic [1:0] rr);
    int ar_k = 0;
    int first = -1;
    bit ar_done = 0, done = 0, ar_fire = 0, r_fire = 0;
    rd = 32'hDEAD_BEEF;
    rr = 2'b11;
    exp_r.push_back(model_read(a));
    for (int k = 0; k < 100 && !done; k++) begin
      @(posedge ACLK); #1;
      if (r_fire) begin
        RREADY = 0;
        done = 1;
        chk("arready_after_r", ARREADY, 1);
      end else begin
        if (ar_fire) begin ARVALID = 0; ar_done = 1; end
        if (!ar_done && k >= ar_dly) begin
          ARVALID = 1; ARADDR = a;
        end
        ar_fire = ARVALID && ARREADY;
        if (ar_fire) ar_k = k;
        if (RVALID) begin
          if (first < 0) begin
            first = k;
            chk("r_latency", k - ar_k - 1, 0);
          end
          rd = RDATA; rr = RRESP;
          if (k - first >= r_dly) RREADY = 1;
          else chk("arready_low_in_r", ARREADY, 0);
        end
        r_fire = RVALID && RREADY;
      end
    end
    if (!done) begin
      n_checks++; n_err++;
      $display("FAIL rd_timeout: got no R for addr %h", a);
      ARVALID = 0; RREADY = 0;
    end
  endtask

  // Single compare point for responses and ALU-facing outputs.
  always @(negedge ACLK) begin
    if (mon_en) begin
      if (BVALID && BREADY) begin
        if (exp_b.size() == 0) chk("bresp_unexpected", 1, 0);
        else chk("bresp", BRESP, exp_b.pop_front());
      end
      if (RVALID && RREADY) begin
        if (exp_r.size() == 0) chk("r_unexpected", 1, 0);
        else chk("rresp_rdata", {RRESP, RDATA},
                 exp_r.pop_front());
      end
      if (!wr_busy) begin
        chk("operandA", operandA, m_opa);
        chk("operandB", operandB, m_opb);
        chk("opp_code", opp_code, m_opc);
      end
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: got hang expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  br, rr;
    logic [31:0] rd;
    ARESETN = 0;
    AWADDR = 0; AWPROT = 0; AWVALID = 1;
    WDATA = 0; WSTRB = 4'hF; WVALID = 1; BREADY = 0;
    ARADDR = 0; ARPROT = 0; ARVALID = 1; RREADY = 0;
    m_opa = 0; m_opb = 0; m_opc = 0; m_cnt = 0;

    repeat (3) @(posedge ACLK);
    #1;
    chk("rst_readys", {AWREADY, WREADY, ARREADY}, 3'b000);
    chk("rst_valids", {BVALID, RVALID}, 2'b00);
    chk("rst_resp", {BRESP, RRESP, RDATA}, 36'h0);
    chk("rst_operands", {operandA, operandB, opp_code}, 19'h0);
    ARESETN = 1;
    AWVALID = 0; WVALID = 0; ARVALID = 0;
    @(negedge ACLK);
    chk("awready_pre_edge", AWREADY, 0);
    @(posedge ACLK); #1;
    chk("readys_after_rst", {AWREADY, WREADY, ARREADY}, 3'b111);
    mon_en = 1;

    do_write(5'h00, 32'h12, 4'hF, 0, 0, 0, br);
    do_write(5'h04, 32'h34, 4'hF, 0, 0, 0, br);
    do_write(5'h08, 32'h0, 4'hF, 0, 0, 0, br);
    do_read(5'h0C, 0, 0, rd, rr);
    chk("add_result", {rr, rd}, 34'h46);

    do_write(5'h00, 32'hF0, 4'hF, 2, 0, 0, br);
    do_write(5'h04, 32'h0F, 4'hF, 2, 0, 0, br);
    do_write(5'h08, 32'h2, 4'hF, 2, 0, 0, br);
    chk("xor_bresp", br, 2'b00);
    do_read(5'h0C, 0, 0, rd, rr);
    chk("xor_result", {rr, rd}, 34'hFF);
    do_write(5'h08, 32'hFFFF_FFF7, 4'hF, 0, 1, 0, br);
    do_read(5'h0C, 0, 0, rd, rr);
    chk("op7_result", {rr, rd}, 34'h0);

    do_write(5'h08, 32'h0, 4'hF, 0, 0, 5, br);
    do_write(5'h04, 32'h0F, 4'hF, 0, 0, 0, br);
    do_read(5'h08, 0, 5, rd, rr);
    chk("bp_read_opcode", {rr, rd}, 34'h0);

    do_write(5'h0C, 32'hAA, 4'hF, 0, 0, 0, br);
    chk("result_wr_bresp", br, 2'b10);
    do_read(5'h0C, 0, 0, rd, rr);
    chk("result_unchanged", {rr, rd}, 34'hFF);
    do_read(5'h14, 0, 0, rd, rr);
    chk("unmapped_read", {rr, rd}, {2'b10, 32'h0});
    do_write(5'h00, 32'h55, 4'b1110, 0, 0, 0, br);
    chk("nostrb_bresp", br, 2'b00);
    do_read(5'h00, 0, 0, rd, rr);
    chk("nostrb_opa", {rr, rd}, 34'hF0);

    // Read captured on the same edge as the OPA commit
    // must still see the old sum.
    fork
      begin
        logic [1:0] b2;
        do_write(5'h00, 32'h01, 4'hF, 0, 0, 0, b2);
      end
      begin
        logic [31:0] r2;
        logic [1:0]  rr2;
        do_read(5'h0C, 1, 0, r2, rr2);
        chk("same_edge_result", {rr2, r2}, 34'hFF);
      end
    join
    do_read(5'h0C, 0, 0, rd, rr);
    chk("post_write_result", {rr, rd}, 34'h10);

`ifdef ALU_AXIL_WR_COUNT_EN
    do_write(5'h10, 32'h0, 4'hF, 0, 0, 0, br);
    chk("cnt_clear_bresp", br, 2'b00);
    do_write(5'h00, 32'h11, 4'hF, 0, 0, 0, br);
    do_write(5'h04, 32'h22, 4'hF, 1, 0, 0, br);
    do_write(5'h08, 32'h1, 4'hF, 0, 1, 0, br);
    do_write(5'h0C, 32'h1, 4'hF, 0, 0, 0, br);
    do_read(5'h10, 0, 0, rd, rr);
    chk("cnt_three", {rr, rd}, 34'h3);
    do_write(5'h10, 32'h5, 4'hF, 0, 0, 0, br);
    do_read(5'h10, 0, 0, rd, rr);
    chk("cnt_cleared", {rr, rd}, 34'h0);
    force dut.wrcnt_q = 32'hFFFF_FFFE;
    @(posedge ACLK); #1;
    release dut.wrcnt_q;
    m_cnt = 32'hFFFF_FFFE;
    do_write(5'h00, 32'h1, 4'hF, 0, 0, 0, br);
    do_write(5'h00, 32'h2, 4'hF, 0, 0, 0, br);
    do_read(5'h10, 0, 0, rd, rr);
    chk("cnt_wrap", {rr, rd}, 34'h0);
`else
    do_read(5'h10, 0, 0, rd, rr);
    chk("wrcnt_unmapped", {rr, rd}, {2'b10, 32'h0});
    do_write(5'h10, 32'h0, 4'hF, 0, 0, 0, br);
    chk("wrcnt_wr_slverr", br, 2'b10);
`endif

    for (int i = 0; i < 80; i++) begin
      logic [4:0] a;
      a = {3'($urandom_range(0, 7)), 2'($urandom)};
      if ($urandom_range(0, 1) == 1)
        do_write(a, $urandom, 4'($urandom),
                 $urandom_range(0, 3), $urandom_range(0, 3),
                 $urandom_range(0, 3), br);
      else
        do_read(a, $urandom_range(0, 3),
                $urandom_range(0, 3), rd, rr);
    end

    repeat (2) @(posedge ACLK);
    #1;
    chk("exp_b_drained", exp_b.size(), 0);
    chk("exp_r_drained", exp_r.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
